prepare_ok_quorum_tracker: RTL and testbench
============================================

Name: prepare_ok_quorum_tracker

Overview:
- Primary-side counterpart to the backup prepare engine: consumes PrepareOK headers returned by backups and tracks per-op acknowledgement masks over a sliding window of outstanding ops.
- Advances the commit point in strict opnum order once a quorum of f backups has acked the head op, emitting one commit per cycle to the commit/execute engine.
- Sits between the UDP receive demux (PrepareOK path) and the primary's commit logic; the primary's prepare issue engine feeds it newly issued opnums.

Parameters:
- NUM_REPLICAS, 3, replica count N; backup quorum QUORUM_OTHERS = NUM_REPLICAS/2 (f).
- REP_IDX_W, $clog2(NUM_REPLICAS), replica index width.
- WINDOW, 16, max outstanding (issued, uncommitted) ops; power of two.
- WIN_W, $clog2(WINDOW), slot index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- my_rep_index  in  REP_IDX_W  this replica's index, static
- curr_view  in  INT_W  current view from VR state
- issue_val  in  1  primary issued a new Prepare
- issue_opnum  in  INT_W  opnum of the issued op
- issue_rdy  out  1  window has a free slot
- ok_val  in  1  PrepareOK header valid
- ok_hdr  in  prepare_ok_hdr  view, opnum, rep_index, last_committed
- ok_rdy  out  1  tracker accepts header
- flush_val  in  1  view-change flush
- flush_commit  in  INT_W  commit point to load on flush
- commit_val  out  1  head op reached quorum
- commit_opnum  out  INT_W  opnum being committed
- commit_rdy  in  1  commit consumer accepts
- last_commit  out  INT_W  highest committed opnum
- last_issued  out  INT_W  highest issued opnum
- drop_cnt  out  16  saturating count of discarded PrepareOKs
- seq_err  out  1  sticky; out-of-order issue seen

Behaviour:
- Reset (rst low, async): last_commit=0, last_issued=0, all slot masks=0, commit_val=0, seq_err=0, drop_cnt=0. issue_rdy=1 and ok_rdy=1 once reset is released.
- Slot of opnum n = n[WIN_W-1:0]; each slot holds an N-bit ack mask. outstanding = last_issued - last_commit (INT_W, wraps mod 2^INT_W).
- issue_rdy = (outstanding < WINDOW) & ~flush_val. An issue is accepted on issue_val&issue_rdy.
  - If issue_opnum == last_issued+1: clear that slot's mask; last_issued <= issue_opnum.
  - Otherwise: ignore the issue and set seq_err.
- ok_rdy = ~flush_val. A header is accepted at cycle T and the mask update is visible at T+1.
- Drop the header (drop_cnt++, saturating at 0xFFFF) if any of:
  - ok_hdr.view != curr_view
  - opnum <= last_commit
  - opnum > last_issued
  - rep_index == my_rep_index
  - rep_index >= NUM_REPLICAS
- Otherwise set mask[slot][rep_index]. A duplicate ack (bit already set) is a no-op and is not counted as a drop.
- Commit FSM has two states:
  - IDLE -> EMIT when outstanding != 0 and popcount(mask[slot(last_commit+1)]) >= QUORUM_OTHERS.
  - In EMIT: commit_val=1 and commit_opnum=last_commit+1, both registered and stable until commit_rdy.
  - On commit_val&commit_rdy: last_commit++, clear the head slot mask, then return to IDLE. Re-evaluation happens next cycle, so back-to-back commits run every other cycle.
- Same-cycle collisions:
  - An ok accepted in the cycle the head retires, targeting the retiring op: discarded silently (not counted). The clear wins.
  - An issue into a slot being cleared by commit: impossible, because outstanding<WINDOW guarantees a distinct slot.
  - An ok and an issue to different slots in the same cycle: both take effect.
- Flush (single-cycle pulse):
  - Clears all masks, last_commit <= flush_commit, last_issued <= flush_commit, FSM -> IDLE, commit_val <= 0.
  - An in-flight commit handshake in that cycle is abandoned.
  - Flush dominates issue and ok in the same cycle.
- Arithmetic: opnum comparisons are unsigned INT_W. Wrap of INT_W opnum space is out of scope.

Decomposition:
- Existing beehive_vr_pkg supplies INT_W and prepare_ok_hdr.
- Add to beehive_vr_pkg:
  - PREP_WINDOW (default for WINDOW)
  - typedef prep_ack_mask (logic [NUM_REPLICAS-1:0])
  - a quorum_others() function
- One sub-module is natural: prep_ack_window. It holds the slot-mask register file (set-bit port, clear port, flush-all) and a combinational popcount of a read slot. The tracker top holds the pointers, drop logic and commit FSM.

Test Plan:
- N=3, my_rep_index=0. Issue ops 1..3; ok(view0, op1, rep1) -> commit_val with commit_opnum=1 two cycles later; last_commit=1 after rdy.
- N=5. Issue op1; ok rep1 -> no commit; ok rep1 again -> still none, drop_cnt=0; ok rep3 -> commit opnum 1.
- Drops: ok with view=1 while curr_view=0; ok for op 7 with last_issued=3; ok from rep0 (self); ok op0 after commit -> drop_cnt=4, masks unchanged.
- Fill window: issue ops 1..16 -> issue_rdy=0; commit op1 -> issue_rdy=1; issue op 18 -> seq_err=1, last_issued=16.
- Acks for ops 1..4 arrive in reverse order (4,3,2,1) -> commits emitted 1,2,3,4 in order, one per two cycles with commit_rdy=1; hold commit_rdy=0 -> commit_val/commit_opnum stable.
- Flush with flush_commit=10 while commit_val high for op 2 -> next cycle commit_val=0, last_commit=10, last_issued=10, issue op 11 accepted. Assert rst low mid-EMIT -> commit_val=0 immediately (async).

Source files
------------

// File: rtl/prepare_ok_quorum_tracker_pkg.sv
// Shared types for the primary-side PrepareOK quorum tracker: header layout,
// ack-mask type and quorum helper.
package prepare_ok_quorum_tracker_pkg;

  localparam int INT_W        = 32;
  localparam int REP_FIELD_W  = 8;
  localparam int PREP_WINDOW  = 16;
  localparam int MAX_REPLICAS = 8;

  typedef struct packed {
    logic [INT_W-1:0]       view;
    logic [INT_W-1:0]       opnum;
    logic [REP_FIELD_W-1:0] rep_index;
    logic [INT_W-1:0]       last_committed;
  } prepare_ok_hdr;

  // Wide enough for any supported replica count; only the low NUM_REPLICAS bits are ever set.
  typedef logic [MAX_REPLICAS-1:0] prep_ack_mask;

  function automatic int quorum_others(input int num_replicas);
    return num_replicas / 2;
  endfunction

endpackage

// File: rtl/prepare_ok_quorum_tracker_prep_ack_window.sv
// Per-slot backup ack masks for outstanding ops, with set/clear/flush ports and a
// combinational popcount of one read slot.
module prepare_ok_quorum_tracker_prep_ack_window
  import prepare_ok_quorum_tracker_pkg::*;
#(
  parameter int WINDOW = PREP_WINDOW,
  parameter int WIN_W  = $clog2(WINDOW),
  parameter int CNT_W  = $clog2(MAX_REPLICAS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             set_i,
  input  logic [WIN_W-1:0] set_idx_i,
  input  prep_ack_mask     set_mask_i,
  input  logic             clr_i,
  input  logic [WIN_W-1:0] clr_idx_i,
  input  logic             iss_clr_i,
  input  logic [WIN_W-1:0] iss_idx_i,
  input  logic [WIN_W-1:0] rd_idx_i,
  output logic [CNT_W-1:0] rd_cnt_o
);

  prep_ack_mask mask_q [WINDOW];

  // Clears beat a set to the same slot: an ack racing its op's retirement is lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WINDOW; i++) mask_q[i] <= '0;
    end else begin
      for (int i = 0; i < WINDOW; i++) begin
        if (flush_i || (clr_i && clr_idx_i == WIN_W'(i)) ||
            (iss_clr_i && iss_idx_i == WIN_W'(i))) begin
          mask_q[i] <= '0;
        end else if (set_i && set_idx_i == WIN_W'(i)) begin
          mask_q[i] <= mask_q[i] | set_mask_i;
        end
      end
    end
  end

  always_comb begin
    rd_cnt_o = '0;
    for (int i = 0; i < MAX_REPLICAS; i++) begin
      rd_cnt_o = rd_cnt_o + CNT_W'(mask_q[rd_idx_i][i]);
    end
  end

endmodule

// File: rtl/prepare_ok_quorum_tracker.sv
// Primary-side PrepareOK tracker: filters acks, keeps issue/commit pointers and
// emits in-order commits once f backups have acked the head op.
module prepare_ok_quorum_tracker
  import prepare_ok_quorum_tracker_pkg::*;
#(
  parameter int NUM_REPLICAS = 3,
  parameter int REP_IDX_W    = $clog2(NUM_REPLICAS),
  parameter int WINDOW       = PREP_WINDOW,
  parameter int WIN_W        = $clog2(WINDOW)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [REP_IDX_W-1:0] my_rep_index_i,
  input  logic [INT_W-1:0]     curr_view_i,
  input  logic                 issue_val_i,
  input  logic [INT_W-1:0]     issue_opnum_i,
  output logic                 issue_rdy_o,
  input  logic                 ok_val_i,
  input  prepare_ok_hdr        ok_hdr_i,
  output logic                 ok_rdy_o,
  input  logic                 flush_val_i,
  input  logic [INT_W-1:0]     flush_commit_i,
  output logic                 commit_val_o,
  output logic [INT_W-1:0]     commit_opnum_o,
  input  logic                 commit_rdy_i,
  output logic [INT_W-1:0]     last_commit_o,
  output logic [INT_W-1:0]     last_issued_o,
  output logic [15:0]          drop_cnt_o,
  output logic                 seq_err_o
);

  localparam int QUORUM_OTHERS = quorum_others(NUM_REPLICAS);
  localparam int CNT_W         = $clog2(MAX_REPLICAS + 1);

  typedef enum logic {S_IDLE, S_EMIT} state_e;

  state_e           state_q;
  logic [INT_W-1:0] last_commit_q, last_issued_q, commit_opnum_q;
  logic             commit_val_q, seq_err_q;
  logic [15:0]      drop_cnt_q;

  logic [INT_W-1:0] outstanding, head_opnum;
  logic             issue_fire, issue_inorder, ok_fire, ok_drop, ok_set, retire;
  logic [CNT_W-1:0] head_cnt;
  prep_ack_mask     set_mask;
  logic             unused_hdr_bits;

  assign outstanding   = last_issued_q - last_commit_q;
  assign head_opnum    = last_commit_q + INT_W'(1);
  assign issue_rdy_o   = (outstanding < INT_W'(WINDOW)) && !flush_val_i;
  assign ok_rdy_o      = !flush_val_i;
  assign issue_fire    = issue_val_i && issue_rdy_o;
  assign issue_inorder = issue_opnum_i == last_issued_q + INT_W'(1);
  assign ok_fire       = ok_val_i && ok_rdy_o;
  assign retire        = commit_val_q && commit_rdy_i;

  assign ok_drop = (ok_hdr_i.view != curr_view_i) ||
                   (ok_hdr_i.opnum <= last_commit_q) ||
                   (ok_hdr_i.opnum > last_issued_q) ||
                   (ok_hdr_i.rep_index == REP_FIELD_W'(my_rep_index_i)) ||
                   (ok_hdr_i.rep_index >= REP_FIELD_W'(NUM_REPLICAS));
  assign ok_set   = ok_fire && !ok_drop;
  assign set_mask = prep_ack_mask'(1) << ok_hdr_i.rep_index[REP_IDX_W-1:0];

  assign unused_hdr_bits = ^ok_hdr_i.last_committed;

  prepare_ok_quorum_tracker_prep_ack_window #(
    .WINDOW (WINDOW),
    .WIN_W  (WIN_W),
    .CNT_W  (CNT_W)
  ) u_window (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_val_i),
    .set_i      (ok_set),
    .set_idx_i  (ok_hdr_i.opnum[WIN_W-1:0]),
    .set_mask_i (set_mask),
    .clr_i      (retire),
    .clr_idx_i  (head_opnum[WIN_W-1:0]),
    .iss_clr_i  (issue_fire && issue_inorder),
    .iss_idx_i  (issue_opnum_i[WIN_W-1:0]),
    .rd_idx_i   (head_opnum[WIN_W-1:0]),
    .rd_cnt_o   (head_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      last_commit_q  <= '0;
      last_issued_q  <= '0;
      commit_opnum_q <= '0;
      commit_val_q   <= 1'b0;
      seq_err_q      <= 1'b0;
      drop_cnt_q     <= '0;
    end else if (flush_val_i) begin
      state_q       <= S_IDLE;
      last_commit_q <= flush_commit_i;
      last_issued_q <= flush_commit_i;
      commit_val_q  <= 1'b0;
    end else begin
      if (issue_fire) begin
        if (issue_inorder) last_issued_q <= issue_opnum_i;
        else               seq_err_q     <= 1'b1;
      end
      if (ok_fire && ok_drop && drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
      // Returning to IDLE after each retire re-reads the next head slot a cycle later.
      case (state_q)
        S_IDLE: begin
          if (outstanding != '0 && head_cnt >= CNT_W'(QUORUM_OTHERS)) begin
            state_q        <= S_EMIT;
            commit_val_q   <= 1'b1;
            commit_opnum_q <= head_opnum;
          end
        end
        S_EMIT: begin
          if (commit_rdy_i) begin
            state_q       <= S_IDLE;
            commit_val_q  <= 1'b0;
            last_commit_q <= head_opnum;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign commit_val_o   = commit_val_q;
  assign commit_opnum_o = commit_opnum_q;
  assign last_commit_o  = last_commit_q;
  assign last_issued_o  = last_issued_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign seq_err_o      = seq_err_q;

endmodule

// File: tb/tb_prepare_ok_quorum_tracker.sv
// Randomized plus directed bench for prepare_ok_quorum_tracker (N=5, f=2) with a
// commit scoreboard fed by a per-op ack-set reference model.
module tb_prepare_ok_quorum_tracker;
  import prepare_ok_quorum_tracker_pkg::*;

  localparam int N      = 5;
  localparam int RW     = $clog2(N);
  localparam int QUORUM = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [RW-1:0]    my_rep = '0;
  logic [31:0]      curr_view = '0;
  logic             issue_val = 1'b0;
  logic [31:0]      issue_opnum = '0;
  logic             issue_rdy;
  logic             ok_val = 1'b0;
  prepare_ok_hdr    ok_hdr = '0;
  logic             ok_rdy;
  logic             flush_val = 1'b0;
  logic [31:0]      flush_commit = '0;
  logic             commit_val;
  logic [31:0]      commit_opnum;
  logic             commit_rdy = 1'b0;
  logic [31:0]      last_commit, last_issued;
  logic [15:0]      drop_cnt;
  logic             seq_err;

  int tests = 0;
  int fails = 0;

  // Reference model: op numbers, per-op ack sets and expected commit order.
  int unsigned m_issued, m_head, dut_commits, m_drops;
  bit          m_seq_err;
  bit [7:0]    acks [int unsigned];
  int unsigned exp_q [$];

  always #5 clk = ~clk;

  prepare_ok_quorum_tracker #(.NUM_REPLICAS(N)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .my_rep_index_i (my_rep),
    .curr_view_i    (curr_view),
    .issue_val_i    (issue_val),
    .issue_opnum_i  (issue_opnum),
    .issue_rdy_o    (issue_rdy),
    .ok_val_i       (ok_val),
    .ok_hdr_i       (ok_hdr),
    .ok_rdy_o       (ok_rdy),
    .flush_val_i    (flush_val),
    .flush_commit_i (flush_commit),
    .commit_val_o   (commit_val),
    .commit_opnum_o (commit_opnum),
    .commit_rdy_i   (commit_rdy),
    .last_commit_o  (last_commit),
    .last_issued_o  (last_issued),
    .drop_cnt_o     (drop_cnt),
    .seq_err_o      (seq_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Commit monitor: pops the scoreboard on every handshake.
  initial begin : monitor
    bit prev_hs;
    int unsigned e;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || flush_val) begin
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) check("commit_gap", commit_val, 0);
        prev_hs = commit_val && commit_rdy;
        if (prev_hs) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_commit: got opnum %0d expected none", commit_opnum);
          end else begin
            e = exp_q.pop_front();
            check("commit_opnum", commit_opnum, e);
            $display("[TB] commit op %0d (expected %0d)", commit_opnum, e);
            dut_commits = e;
          end
        end
      end
    end
  end

  // One clock of stimulus: inputs already driven; returns 1 time unit after the edge.
  task automatic step();
    int unsigned c_snap, op, rep;
    bit iss_acc, drop, room;
    c_snap = dut_commits;
    @(negedge clk);
    room = ((m_issued - c_snap) < 16);
    check("last_commit", last_commit, c_snap);
    check("last_issued", last_issued, m_issued);
    check("issue_rdy", issue_rdy, room && !flush_val);
    check("ok_rdy", ok_rdy, !flush_val);
    iss_acc = issue_val && room;
    if (flush_val) begin
      m_issued = flush_commit;
      m_head = flush_commit;
      dut_commits = flush_commit;
      acks.delete();
      exp_q.delete();
    end else begin
      if (ok_val) begin
        op  = ok_hdr.opnum;
        rep = ok_hdr.rep_index;
        drop = (ok_hdr.view != curr_view) || (op <= c_snap) || (op > m_issued) ||
               (rep == my_rep) || (rep >= N);
        if (drop) m_drops++;
        else if (op > m_head) acks[op] |= 8'(1) << rep;
      end
      if (iss_acc) begin
        if (issue_opnum == m_issued + 1) begin
          m_issued++;
          acks[m_issued] = '0;
        end else begin
          m_seq_err = 1'b1;
        end
      end
      while (m_head < m_issued && $countones(acks[m_head + 1]) >= QUORUM) begin
        m_head++;
        exp_q.push_back(m_head);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_issue(input int unsigned op);
    issue_val = 1'b1;
    issue_opnum = op;
    step();
    issue_val = 1'b0;
  endtask

  task automatic send_ok(input int unsigned op, input int unsigned rep, input int unsigned view);
    ok_val = 1'b1;
    ok_hdr.view = view;
    ok_hdr.opnum = op;
    ok_hdr.rep_index = 8'(rep);
    ok_hdr.last_committed = '0;
    step();
    ok_val = 1'b0;
  endtask

  task automatic drain();
    commit_rdy = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
    idle(3);
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    issue_val = 1'b0;
    ok_val = 1'b0;
    flush_val = 1'b0;
    commit_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_issued = 0; m_head = 0; dut_commits = 0; m_drops = 0; m_seq_err = 1'b0;
    acks.delete();
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    check("rst_last_commit", last_commit, 0);
    check("rst_last_issued", last_issued, 0);
    check("rst_commit_val", commit_val, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_issue_rdy", issue_rdy, 1);
    check("rst_ok_rdy", ok_rdy, 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Randomized phase.
    curr_view = 32'd3;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      int unsigned c, op, rep, view;
      int kind;
      c = dut_commits;
      issue_val = ($urandom_range(0, 9) < 4);
      issue_opnum = ($urandom_range(0, 29) == 0) ? m_issued + 2 : m_issued + 1;
      ok_val = ($urandom_range(0, 9) < 6);
      op = (m_issued > c) ? c + 1 + $urandom_range(0, m_issued - c - 1) : m_issued + 1;
      rep = $urandom_range(1, N - 1);
      view = curr_view;
      kind = $urandom_range(0, 9);
      case (kind)
        0: view = curr_view + 1;
        1: rep = my_rep;
        2: rep = $urandom_range(N, 255);
        3: op = m_issued + 1 + $urandom_range(0, 3);
        4: op = $urandom_range(0, c);
        default: ;
      endcase
      ok_hdr.view = view;
      ok_hdr.opnum = op;
      ok_hdr.rep_index = 8'(rep);
      ok_hdr.last_committed = $urandom;
      commit_rdy = ($urandom_range(0, 9) < 7);
      step();
    end
    issue_val = 1'b0;
    ok_val = 1'b0;
    drain();
    check("rand_drop_cnt", drop_cnt, m_drops);
    check("rand_seq_err", seq_err, m_seq_err);
    check("rand_last_commit", last_commit, m_head);
    check("rand_last_issued", last_issued, m_issued);

    // Directed: quorum of two, duplicate ack, commit latency and hold.
    curr_view = 32'd0;
    do_reset();
    send_issue(1);
    send_ok(1, 1, 0);
    idle(3);
    check("one_ack_no_commit", commit_val, 0);
    send_ok(1, 1, 0);
    idle(3);
    check("dup_no_commit", commit_val, 0);
    check("dup_not_dropped", drop_cnt, 0);
    send_ok(1, 3, 0);
    check("commit_lat_t1", commit_val, 0);
    idle(1);
    check("commit_lat_t2", commit_val, 1);
    check("commit_lat_op", commit_opnum, 1);
    idle(3);
    check("hold_val", commit_val, 1);
    check("hold_op", commit_opnum, 1);
    drain();
    check("after_op1", last_commit, 1);

    // Drops leave masks untouched.
    send_issue(2);
    send_issue(3);
    send_ok(2, 1, 1);
    send_ok(7, 1, 0);
    send_ok(2, 0, 0);
    send_ok(0, 1, 0);
    check("drop_cnt4", drop_cnt, 4);
    send_ok(3, 6, 0);
    check("drop_cnt5", drop_cnt, 5);
    send_ok(2, 2, 0);
    idle(4);
    check("masks_intact", commit_val, 0);
    send_ok(2, 4, 0);
    send_ok(3, 1, 0);
    send_ok(3, 2, 0);
    drain();
    check("after_op3", last_commit, 3);

    // Reverse-order acks commit in opnum order.
    for (int op = 4; op <= 7; op++) send_issue(op);
    for (int op = 7; op >= 5; op--) begin
      send_ok(op, 1, 0);
      send_ok(op, 2, 0);
    end
    idle(2);
    check("rev_blocked", commit_val, 0);
    send_ok(4, 1, 0);
    send_ok(4, 2, 0);
    drain();
    check("after_op7", last_commit, 7);

    // Window full, then out-of-order issue.
    for (int op = 8; op <= 23; op++) send_issue(op);
    check("full_issue_rdy", issue_rdy, 0);
    send_issue(24);
    check("full_rejects", last_issued, 23);
    send_ok(8, 1, 0);
    send_ok(8, 3, 0);
    drain();
    check("room_issue_rdy", issue_rdy, 1);
    send_issue(25);
    check("seq_err_set", seq_err, 1);
    check("seq_err_ignored", last_issued, 23);

    // Flush abandons an in-flight commit.
    commit_rdy = 1'b0;
    send_ok(9, 1, 0);
    send_ok(9, 2, 0);
    idle(2);
    check("pre_flush_val", commit_val, 1);
    check("pre_flush_op", commit_opnum, 9);
    commit_rdy = 1'b1;
    flush_val = 1'b1;
    flush_commit = 32'd40;
    step();
    flush_val = 1'b0;
    check("flush_commit_val", commit_val, 0);
    check("flush_last_commit", last_commit, 40);
    check("flush_last_issued", last_issued, 40);
    send_issue(41);
    check("post_flush_issue", last_issued, 41);
    send_ok(41, 1, 0);
    send_ok(41, 4, 0);
    drain();
    check("after_op41", last_commit, 41);

    // Asynchronous reset during EMIT.
    commit_rdy = 1'b0;
    send_issue(42);
    send_ok(42, 2, 0);
    send_ok(42, 3, 0);
    idle(2);
    check("pre_rst_val", commit_val, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_val", commit_val, 0);
    check("async_rst_commit", last_commit, 0);
    do_reset();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
